// File: rtl/rv32_hazard_ctrl_pkg.sv
// Shared encodings for the RV32 hazard/forwarding controller:
// forward-select codes, FSM state codes and the scoreboard flag bundle.
package rv32_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    typedef struct packed {
        logic v;
        logic regwr;
    } sb_flag_t;

endpackage

// File: rtl/rv32_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle.
// master: pipeline side (drives ID fields, redirect, resume).
// slave: controller side (drives hold/bubble/flush, fwd, status).
interface rv32_hazard_ctrl_if #(
    parameter int REG_AW  = 5,
    parameter int RDR_STG = 3,
    parameter int CNT_W   = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use1;
    logic              id_use2;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwr;
    logic              id_memrd;
    logic              id_halt;
    logic              redirect;
    logic              resume;
    logic               hold_pc;
    logic               hold_ifid;
    logic               bubble_ex;
    logic [RDR_STG-1:0] flush_o;
    logic [1:0]         fwd_a;
    logic [1:0]         fwd_b;
    logic               halted;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use1, id_use2,
        output id_rd, id_regwr, id_memrd, id_halt,
        output redirect, resume,
        input  hold_pc, hold_ifid, bubble_ex, flush_o,
        input  fwd_a, fwd_b, halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use1, id_use2,
        input  id_rd, id_regwr, id_memrd, id_halt,
        input  redirect, resume,
        output hold_pc, hold_ifid, bubble_ex, flush_o,
        output fwd_a, fwd_b, halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/rv32_hazard_ctrl_sb_entry_cmp.sv
// Compare one source operand against one scoreboard entry.
// Ports: src_use/src (operand), ent_v/ent_regwr/ent_rd (entry), hit.
module sb_entry_cmp #(
    parameter int REG_AW = 5
) (
    input  logic              src_use,
    input  logic [REG_AW-1:0] src,
    input  logic              ent_v,
    input  logic              ent_regwr,
    input  logic [REG_AW-1:0] ent_rd,
    output logic              hit
);
    assign hit = src_use && ent_v && ent_regwr &&
                 (ent_rd != '0) && (ent_rd == src);
endmodule

// File: rtl/rv32_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage RV32 pipeline.
// Ports: clk, rst (async, active-low), hz (slave side of the bundle).
module rv32_hazard_ctrl
    import rv32_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int FWD_EN   = 1,
    parameter int LOAD_LAT = 1,
    parameter int RDR_STG  = 3,
    parameter int CNT_W    = 16
) (
    input logic               clk,
    input logic               rst,
    rv32_hazard_ctrl_if.slave hz
);
    // The detect cycle is the first bubble; STALL covers the rest.
    localparam logic [1:0] LAT_M1 = 2'(LOAD_LAT - 1);

    sb_flag_t          ex_f, mem_f, wb_f;
    logic              ex_ld, ex_use1, ex_use2;
    logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd, ex_rs1, ex_rs2;
    logic [1:0]        st, st_n, lcnt, lc_n;
    logic              res_lock;
    logic [CNT_W-1:0]  s_cnt, f_cnt;

    // 0/1: ID vs EX, 2/3: ID vs MEM, 4/5: EX vs MEM, 6/7: EX vs WB
    logic [7:0]        c_use, hit;
    logic [REG_AW-1:0] c_src [8];
    logic [3:0]        e_v, e_wr;
    logic [REG_AW-1:0] e_rd [4];

    assign c_use = {ex_use2 & ex_f.v, ex_use1 & ex_f.v,
                    ex_use2 & ex_f.v, ex_use1 & ex_f.v,
                    hz.id_use2, hz.id_use1,
                    hz.id_use2, hz.id_use1};
    assign c_src = '{hz.id_rs1, hz.id_rs2, hz.id_rs1, hz.id_rs2,
                     ex_rs1, ex_rs2, ex_rs1, ex_rs2};
    assign e_v   = {wb_f.v, mem_f.v, mem_f.v, ex_f.v};
    assign e_wr  = {wb_f.regwr, mem_f.regwr, mem_f.regwr, ex_f.regwr};
    assign e_rd  = '{ex_rd, mem_rd, mem_rd, wb_rd};

    for (genvar g = 0; g < 8; g++) begin : g_cmp
        sb_entry_cmp #(.REG_AW(REG_AW)) u_cmp (
            .src_use   (c_use[g]),
            .src       (c_src[g]),
            .ent_v     (e_v[g/2]),
            .ent_regwr (e_wr[g/2]),
            .ent_rd    (e_rd[g/2]),
            .hit       (hit[g])
        );
    end

    logic lu, raw, stall_act, halt_go, res_ok, hold, adv;
    logic [1:0] fa, fb;

    assign lu  = hz.id_valid && (hit[0] || hit[1]) && ex_ld;
    // WB matches are covered by the write-first register file.
    assign raw = hz.id_valid && (|hit[3:0]);

    always_comb begin
        stall_act = 1'b0;
        if (!hz.redirect) begin
            if (FWD_EN != 0)
                stall_act = (st == ST_STALL) || (st == ST_RUN && lu);
            else
                stall_act = (st != ST_HALT) && raw;
        end
    end

    assign halt_go = hz.id_valid && hz.id_halt && !hz.redirect &&
                     !stall_act && (st != ST_HALT);
    // A resume held high releases HALT once; it must drop to re-arm.
    assign res_ok  = (st == ST_HALT) && hz.resume && !res_lock;
    assign hold    = !hz.redirect &&
                     (stall_act || halt_go || (st == ST_HALT && !res_ok));
    assign adv     = hz.id_valid && !hold && !hz.redirect;

    always_comb begin
        fa = FWD_RF;
        fb = FWD_RF;
        if (FWD_EN != 0) begin
            if (hit[4])      fa = FWD_EXMEM;
            else if (hit[6]) fa = FWD_MEMWB;
            if (hit[5])      fb = FWD_EXMEM;
            else if (hit[7]) fb = FWD_MEMWB;
        end
    end

    always_comb begin
        st_n = st;
        lc_n = lcnt;
        if (hz.redirect) begin
            st_n = ST_RUN;
            lc_n = '0;
        end else if (st == ST_HALT) begin
            if (res_ok) st_n = ST_RUN;
        end else if (stall_act) begin
            if (FWD_EN == 0) begin
                st_n = ST_STALL;
            end else if (st == ST_RUN) begin
                st_n = (LOAD_LAT > 1) ? ST_STALL : ST_RUN;
                lc_n = LAT_M1;
            end else begin
                lc_n = lcnt - 2'd1;
                st_n = (lcnt == 2'd1) ? ST_RUN : ST_STALL;
            end
        end else if (halt_go) begin
            st_n = ST_HALT;
        end else begin
            st_n = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st       <= ST_RUN;
            lcnt     <= '0;
            res_lock <= 1'b0;
            s_cnt    <= '0;
            f_cnt    <= '0;
        end else begin
            st       <= st_n;
            lcnt     <= lc_n;
            res_lock <= hz.resume && (res_lock || res_ok);
            if (stall_act && s_cnt != '1) s_cnt <= s_cnt + 1'b1;
            if (hz.redirect && f_cnt != '1) f_cnt <= f_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_f    <= '0;
            mem_f   <= '0;
            wb_f    <= '0;
            ex_ld   <= 1'b0;
            ex_use1 <= 1'b0;
            ex_use2 <= 1'b0;
            ex_rs1  <= '0;
            ex_rs2  <= '0;
            ex_rd   <= '0;
            mem_rd  <= '0;
            wb_rd   <= '0;
        end else begin
            ex_f    <= adv ? '{1'b1, hz.id_regwr} : '0;
            ex_ld   <= adv && hz.id_memrd;
            ex_use1 <= hz.id_use1;
            ex_use2 <= hz.id_use2;
            ex_rs1  <= hz.id_rs1;
            ex_rs2  <= hz.id_rs2;
            ex_rd   <= hz.id_rd;
            if (hz.redirect && RDR_STG > 2) mem_f <= '0;
            else                            mem_f <= ex_f;
            mem_rd  <= ex_rd;
            wb_f    <= mem_f;
            wb_rd   <= mem_rd;
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign hz.hold_pc   = rst && hold;
    assign hz.hold_ifid = rst && hold;
    assign hz.bubble_ex = rst && hold;
    assign hz.flush_o   = {RDR_STG{rst && hz.redirect}};
    assign hz.fwd_a     = rst ? fa : FWD_RF;
    assign hz.fwd_b     = rst ? fb : FWD_RF;
    assign hz.halted    = (st == ST_HALT);
    assign hz.stall_cnt = s_cnt;
    assign hz.flush_cnt = f_cnt;
endmodule
